mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-client (instruction fetch / data) arbiter onto one shared RAM port, with alternating
// tie-break fairness, per-access timeout abort and a sticky error flag.
// Optional stall counters (istall_cnt/dstall_cnt) are built when MEM_ARBITER_PERF_EN is defined.
module mem_arbiter #(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              ihit,
    output logic [WORD_W-1:0] iload,
    output logic              dhit,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic              ram_ready,
    output logic              timeout_err,
    output logic [1:0]        fsm_state
`ifdef MEM_ARBITER_PERF_EN
    ,
    output logic [31:0]       istall_cnt,
    output logic [31:0]       dstall_cnt
`endif
);

    // Handshake: a client request (iREN, or dREN|dWEN) is held until its hit pulse; the RAM
    // completes an access in the first cycle ram_ready=1 while ramREN or ramWEN is driven.
    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSERV = 2'd1,
        ISERV = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                last_data_q, last_data_d;
    logic                err_q, err_d;

    logic                d_req;
    logic                ren_c, wen_c, ihit_c, dhit_c;
    logic [WORD_W-1:0]   addr_c, store_c, iload_c, dload_c;

    assign d_req = dREN | dWEN;

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        last_data_d = last_data_q;
        err_d       = err_q;
        ren_c       = 1'b0;
        wen_c       = 1'b0;
        addr_c      = '0;
        store_c     = '0;
        ihit_c      = 1'b0;
        dhit_c      = 1'b0;
        iload_c     = '0;
        dload_c     = '0;
        case (state_q)
            IDLE: begin
                wait_d = '0;
                // On a tie, data wins unless data took the previous completion.
                if (d_req && (!iREN || !last_data_q)) begin
                    state_d = DSERV;
                end else if (iREN) begin
                    state_d = ISERV;
                end
            end
            DSERV: begin
                addr_c = daddr;
                if (dWEN) begin
                    wen_c   = 1'b1;
                    store_c = dstore;
                end else begin
                    ren_c = 1'b1;
                end
                if (!d_req) begin
                    state_d = IDLE;
                end else if (ram_ready) begin
                    dhit_c      = 1'b1;
                    dload_c     = dWEN ? '0 : ramload;
                    last_data_d = 1'b1;
                    state_d     = IDLE;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ISERV: begin
                ren_c  = 1'b1;
                addr_c = iaddr;
                if (!iREN) begin
                    state_d = IDLE;
                end else if (ram_ready) begin
                    ihit_c      = 1'b1;
                    iload_c     = ramload;
                    last_data_d = 1'b0;
                    state_d     = IDLE;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            last_data_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            last_data_q <= last_data_d;
            err_q       <= err_d;
        end
    end

    // All outputs are forced low for as long as reset is asserted, not just after the edge.
    always_comb begin
        ramREN      = nRST & ren_c;
        ramWEN      = nRST & wen_c;
        ramaddr     = nRST ? addr_c  : '0;
        ramstore    = nRST ? store_c : '0;
        ihit        = nRST & ihit_c;
        dhit        = nRST & dhit_c;
        iload       = nRST ? iload_c : '0;
        dload       = nRST ? dload_c : '0;
        timeout_err = nRST & err_q;
        fsm_state   = nRST ? 2'(state_q) : 2'b00;
    end

`ifdef MEM_ARBITER_PERF_EN
    logic [31:0] istall_q, dstall_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            istall_q <= '0;
            dstall_q <= '0;
        end else begin
            if (iREN && !ihit_c && (istall_q != '1)) istall_q <= istall_q + 32'd1;
            if (d_req && !dhit_c && (dstall_q != '1)) dstall_q <= dstall_q + 32'd1;
        end
    end

    assign istall_cnt = nRST ? istall_q : '0;
    assign dstall_cnt = nRST ? dstall_q : '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: RAM responder model, request driver tasks and a
// scoreboard that predicts each hit (client, write flag, address, data) when it is requested.
module tb_mem_arbiter;

  localparam int W  = 32;
  localparam int TO = 4;
  localparam int EW = 2 + 2 * W;
  localparam logic [W-1:0] KEY = 32'hDEADBFEF;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         iREN, dREN, dWEN;
  logic [W-1:0] iaddr, daddr, dstore;
  logic         ihit, dhit, ramREN, ramWEN, ram_ready, timeout_err;
  logic [W-1:0] iload, dload, ramaddr, ramstore, ramload;
  logic [1:0]   fsm_state;
`ifdef MEM_ARBITER_PERF_EN
  logic [31:0]  istall_cnt, dstall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];

  mem_arbiter #(.WORD_W(W), .TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready),
    .timeout_err(timeout_err), .fsm_state(fsm_state)
`ifdef MEM_ARBITER_PERF_EN
    , .istall_cnt(istall_cnt), .dstall_cnt(dstall_cnt)
`endif
  );

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // RAM responder: ready after ram_lat busy cycles; read data is address ^ KEY
  int   ram_lat  = 0;
  logic ram_dead = 1'b0;
  int   busy_cnt = 0;
  logic ram_active;

  assign ram_active = ramREN | ramWEN;

  always_comb begin
    ram_ready = ram_active && !ram_dead && (busy_cnt >= ram_lat);
    ramload   = ramREN ? (ramaddr ^ KEY) : '0;
  end

  always @(posedge CLK) busy_cnt <= (ram_active && !ram_ready) ? busy_cnt + 1 : 0;

  task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack(input logic is_i, input logic wr,
                                         input logic [W-1:0] a, input logic [W-1:0] d);
    return {is_i, wr, a, d};
  endfunction

  // scoreboard monitor
  logic [EW-1:0] mon_got;

  always @(negedge CLK) begin
    if (nRST) begin
      if (fsm_state == 2'd0) check("idle_port", {ramREN, ramWEN, ramaddr, ramstore}, '0);
      if (ihit || dhit) begin
        check("hit_exclusive", {1'b0, ihit & dhit}, '0);
        check("hit_not_idle", {1'b0, fsm_state == 2'd0}, '0);
        if (ramWEN) check("write_hit_no_read", {ramREN, dload}, '0);
        mon_got = pack(ihit, ramWEN, ramaddr, ihit ? iload : (ramWEN ? ramstore : dload));
        if (exp_q.size() == 0) check("sb_unexpected_hit", exp_q.size(), 1);
        else check("sb_hit", mon_got, exp_q.pop_front());
      end else begin
        check("load_zero_no_hit", {iload, dload}, '0);
      end
    end
  end

  // driver tasks
  task automatic clear_inputs();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
  endtask

  task automatic apply_reset();
    @(posedge CLK); #1;
    nRST = 1'b0;
    clear_inputs();
    ram_dead = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_ctl", {ihit, dhit, ramREN, ramWEN, timeout_err, fsm_state}, '0);
    check("rst_addr", {ramaddr, ramstore}, '0);
    check("rst_load", {iload, dload}, '0);
`ifdef MEM_ARBITER_PERF_EN
    check("rst_perf", {istall_cnt, dstall_cnt}, '0);
`endif
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  task automatic do_req(input logic is_i, input logic rd, input logic wr,
                        input logic [W-1:0] a, input logic [W-1:0] s, input int lat);
    int  cyc;
    logic seen;
    ram_lat = lat;
    @(posedge CLK); #1;
    if (is_i) begin
      iREN = 1'b1; iaddr = a;
      exp_q.push_back(pack(1'b1, 1'b0, a, a ^ KEY));
    end else begin
      dREN = rd; dWEN = wr; daddr = a; dstore = s;
      exp_q.push_back(pack(1'b0, wr, a, wr ? s : (a ^ KEY)));
    end
    cyc  = 0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (ihit || dhit) begin
        seen = 1'b1;
        break;
      end
      cyc++;
    end
    check("hit_latency", seen ? cyc : 999, lat + 1);
    @(posedge CLK); #1;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
  endtask

  initial begin
    int hits, last_hit, n;
    logic [W-1:0] ra;
    nRST = 1'b0;
    clear_inputs();
    apply_reset();

    // data read, ready in first service cycle: dload = DEADBEEF
    do_req(1'b0, 1'b1, 1'b0, 32'h100, '0, 0);
    // read+write together is a write
    do_req(1'b0, 1'b1, 1'b1, 32'h40, 32'h5, 0);
    do_req(1'b1, 1'b0, 1'b0, 32'h800, '0, 1);
    do_req(1'b0, 1'b0, 1'b1, 32'h1234, 32'hCAFEF00D, 3);
    for (int t = 0; t < 10; t++) begin
      ra = $urandom;
      case ($urandom_range(0, 2))
        0:       do_req(1'b1, 1'b0, 1'b0, ra, '0, $urandom_range(0, 3));
        1:       do_req(1'b0, 1'b1, 1'b0, ra, '0, $urandom_range(0, 3));
        default: do_req(1'b0, 1'b0, 1'b1, ra, $urandom, $urandom_range(0, 3));
      endcase
    end

    // data read withdrawn mid-wait: no hit, back to IDLE, fairness untouched
    apply_reset();
    ram_dead = 1'b1;
    @(posedge CLK); #1;
    dREN = 1'b1; daddr = 32'h900;
    @(negedge CLK);
    @(negedge CLK);
    check("withdraw_active", {1'b0, ramREN}, 1);
    #2 dREN = 1'b0;
    @(negedge CLK);
    check("withdraw_idle", {fsm_state, timeout_err}, '0);
    ram_dead = 1'b0;

    // collision held: D write, I, D write, I with one IDLE cycle between services
    ram_lat = 1;
    exp_q.push_back(pack(1'b0, 1'b1, 32'h3000, 32'h77));
    exp_q.push_back(pack(1'b1, 1'b0, 32'h2000, 32'h2000 ^ KEY));
    exp_q.push_back(pack(1'b0, 1'b1, 32'h3000, 32'h77));
    exp_q.push_back(pack(1'b1, 1'b0, 32'h2000, 32'h2000 ^ KEY));
    @(posedge CLK); #1;
    iREN = 1'b1; iaddr = 32'h2000;
    dWEN = 1'b1; daddr = 32'h3000; dstore = 32'h77;
    hits = 0;
    last_hit = 0;
    for (int k = 1; k <= 60 && hits < 4; k++) begin
      @(negedge CLK);
      if (ihit || dhit) begin
        if (hits > 0) check("collision_gap", k - last_hit, 3);
        last_hit = k;
        hits++;
      end
    end
    check("collision_hits", hits, 4);
    @(posedge CLK); #1;
    clear_inputs();

    // timeout: RAM never ready, abort after TO wait cycles, sticky error
    apply_reset();
    ram_dead = 1'b1;
    @(posedge CLK); #1;
    iREN = 1'b1; iaddr = 32'hA0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (ramREN) break;
    end
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (!ramREN) break;
      n++;
      @(negedge CLK);
    end
    check("timeout_cycles", n, TO);
    check("timeout_err_set", {fsm_state, timeout_err}, 1);
    #2 iREN = 1'b0;
    repeat (3) @(negedge CLK);
    check("timeout_err_sticky", {1'b0, timeout_err}, 1);
    ram_dead = 1'b0;
    apply_reset();

    // reset during a data wait: outputs low at once, state IDLE afterwards, no hit
    ram_dead = 1'b1;
    @(posedge CLK); #1;
    dREN = 1'b1; daddr = 32'h500;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (ramREN) break;
    end
    #2 nRST = 1'b0;
    #1 check("rst_mid_outputs", {ramREN, ramWEN, dhit, ramaddr, fsm_state}, '0);
    @(negedge CLK);
    #2 nRST = 1'b1; dREN = 1'b0;
    #1 check("rst_mid_idle", {fsm_state, ramREN, ramaddr}, '0);
    ram_dead = 1'b0;
    repeat (2) @(negedge CLK);

`ifdef MEM_ARBITER_PERF_EN
    apply_reset();
    do_req(1'b1, 1'b0, 1'b0, 32'h60, '0, 2);
    @(negedge CLK);
    check("perf_istall", istall_cnt, 3);
    check("perf_dstall", dstall_cnt, 0);
`endif

    repeat (3) @(negedge CLK);
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
